// File: rtl/toggle_cover_collector.sv
// rtl/toggle_cover_collector.sv - sticky toggle-coverage collector draining first hits over a valid/ready stream
module toggle_cover_collector #(
  parameter int N           = 11,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 28338,
  parameter int INDEX_W     = 32,
  localparam int CNT_W      = $clog2(N + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       valid,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] out_index,
  output logic [CNT_W-1:0]   hit_count,
  output logic               all_covered
);

  localparam logic [CNT_W:0] N_EXT = (CNT_W + 1)'(N);

  // The local cover range must sit inside the global space and be addressable.
  if ((COVER_INDEX + N > COVER_TOTAL) ||
      ((INDEX_W < 31) && (COVER_TOTAL - 1 >= (1 << INDEX_W)))) begin : g_bad_params
    $error("toggle_cover_collector: cover range does not fit COVER_TOTAL/INDEX_W");
  end

  logic [N-1:0]       sticky;
  logic [N-1:0]       pending;
  logic [N-1:0]       new_hits;
  logic [N-1:0]       pick_mask;
  logic [N-1:0]       pending_next;
  logic [INDEX_W-1:0] pick_index;
  logic               pick_any;
  logic               load;
  logic [CNT_W-1:0]   new_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [CNT_W:0]     cnt_sum;

  // First hits this cycle and the resulting distinct-hit count (saturating at N).
  always_comb begin
    new_hits = valid & ~sticky;
    new_cnt  = '0;
    for (int i = 0; i < N; i++) begin
      new_cnt = new_cnt + CNT_W'(new_hits[i]);
    end
    cnt_sum  = {1'b0, hit_count} + {1'b0, new_cnt};
    cnt_next = (cnt_sum > N_EXT) ? CNT_W'(N) : cnt_sum[CNT_W-1:0];
  end

  // Lowest registered pending bit is the next point to present; new hits join pending a cycle later.
  always_comb begin
    pick_mask  = '0;
    pick_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_mask    = '0;
        pick_mask[i] = 1'b1;
        pick_index   = INDEX_W'(COVER_INDEX) + INDEX_W'(i);
      end
    end
    pick_any     = |pending;
    load         = !out_valid || out_ready;
    pending_next = (pending & ~(load ? pick_mask : '0)) | new_hits;
  end

  // Coverage state plus the registered output stage; clear drops everything including an in-flight report.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sticky    <= '0;
      pending   <= '0;
      hit_count <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
    end else if (clear) begin
      sticky    <= '0;
      pending   <= '0;
      hit_count <= '0;
      out_valid <= 1'b0;
    end else begin
      sticky    <= sticky | valid;
      pending   <= pending_next;
      hit_count <= cnt_next;
      if (load) begin
        out_valid <= pick_any;
        if (pick_any) begin
          out_index <= pick_index;
        end
      end
    end
  end

  assign all_covered = (hit_count == CNT_W'(N));

`ifndef SYNTHESIS
  a_stall_stable: assert property (@(posedge clock) disable iff (reset)
    (out_valid && !out_ready && !clear) |=> (out_valid && $stable(out_index)));
  a_count_matches: assert property (@(posedge clock) disable iff (reset)
    $countones(sticky) == int'(hit_count));
  a_pending_subset: assert property (@(posedge clock) disable iff (reset)
    (pending & ~sticky) == '0);
`endif

endmodule

// File: tb/tb_toggle_cover_collector.sv
// tb/tb_toggle_cover_collector.sv - scoreboard bench for toggle_cover_collector
module tb_toggle_cover_collector;

  localparam int N  = 11;
  localparam int CI = 100;
  localparam int CW = $clog2(N + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  valid = '0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [31:0]   out_index;
  logic [CW-1:0] hit_count;
  logic          all_covered;

  int total = 0;
  int bad   = 0;

  int exp_q[$];
  bit m_sticky[N];
  bit m_pend[N];
  bit m_pv;
  int m_pi;
  int m_cnt;
  bit seen[N];

  toggle_cover_collector #(
    .N(N), .COVER_INDEX(CI), .COVER_TOTAL(28338), .INDEX_W(32)
  ) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .hit_count(hit_count), .all_covered(all_covered)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < N; i++) begin
      m_sticky[i] = 1'b0;
      m_pend[i]   = 1'b0;
    end
    m_pv  = 1'b0;
    m_pi  = 0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // Reference: set of hit points, set of unreported points, one presented slot.
  task automatic step(input logic [N-1:0] v, input logic rdy, input logic clr);
    int k;
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        m_sticky[i] = 1'b0;
        m_pend[i]   = 1'b0;
      end
      m_pv  = 1'b0;
      m_cnt = 0;
      return;
    end
    if (m_pv && rdy) exp_q.push_back(m_pi);
    if (!m_pv || rdy) begin
      k = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) k = i;
      if (k >= 0) begin
        m_pv = 1'b1;
        m_pi = CI + k;
        m_pend[k] = 1'b0;
      end else begin
        m_pv = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (v[i] === 1'b1 && !m_sticky[i]) begin
        m_sticky[i] = 1'b1;
        m_pend[i]   = 1'b1;
        m_cnt++;
      end
    end
  endtask

  task automatic chk_state();
    chk("out_valid", out_valid, m_pv);
    if (m_pv) chk("out_index", out_index, m_pi);
    chk("hit_count", hit_count, m_cnt);
    chk("all_covered", all_covered, m_cnt == N);
    chk("hit_count_le_n", hit_count <= N, 1);
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic clr);
    @(posedge clock);
    #1;
    chk_state();
    valid     = v;
    out_ready = rdy;
    clear     = clr;
    step(v, rdy, clr);
  endtask

  // Monitor: pop expected index on every accepted transfer; also checks once-per-epoch.
  always @(negedge clock) begin
    int e;
    int k;
    if (reset || clear) begin
      for (int i = 0; i < N; i++) seen[i] = 1'b0;
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL xfer_unexpected: actual=%0d required=none", out_index);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_index", out_index, e);
      end
      k = int'(out_index) - CI;
      chk("xfer_range", (k >= 0 && k < N), 1);
      if (k >= 0 && k < N) begin
        chk("xfer_dup", seen[k], 0);
        seen[k] = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mreset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_all_covered", all_covered, 0);
    reset = 1'b0;

    // single hit, latency 2, repeat hit ignored
    cycle(11'h001, 1, 0);
    cycle(11'h000, 1, 0);
    cycle(11'h000, 1, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_index", out_index, 100);
    chk("t1_count", hit_count, 1);
    cycle(11'h001, 1, 0);
    repeat (4) cycle(11'h000, 1, 0);
    chk("t1_no_repeat", out_valid, 0);
    chk("t1_count_hold", hit_count, 1);

    // all points at once, ascending drain
    cycle(11'h000, 1, 1);
    cycle(11'h7FF, 1, 0);
    cycle(11'h000, 1, 0);
    chk("t2_count", hit_count, 11);
    chk("t2_all", all_covered, 1);
    for (int k = 0; k < N; k++) begin
      cycle(11'h000, 1, 0);
      chk("t2_order_valid", out_valid, 1);
      chk("t2_order", out_index, 100 + k);
    end
    cycle(11'h000, 1, 0);
    chk("t2_drained", out_valid, 0);

    // backpressure with an overtaking lower bit
    cycle(11'h000, 1, 1);
    cycle(11'h024, 0, 0);
    cycle(11'h000, 0, 0);
    for (int h = 0; h < 4; h++) begin
      cycle(11'h000, 0, 0);
      chk("t3_hold", out_index, 102);
    end
    cycle(11'h001, 0, 0);
    chk("t3_hold_last", out_index, 102);
    cycle(11'h000, 1, 0);
    chk("t3_seq0", out_index, 102);
    cycle(11'h000, 1, 0);
    chk("t3_seq1", out_index, 100);
    cycle(11'h000, 1, 0);
    chk("t3_seq2", out_index, 105);
    cycle(11'h000, 1, 0);
    chk("t3_done", out_valid, 0);

    // clear wins over simultaneous valid and an accepted transfer
    cycle(11'h000, 1, 1);
    cycle(11'h003, 1, 0);
    cycle(11'h000, 1, 0);
    cycle(11'h010, 1, 1);
    chk("t4_pre_valid", out_valid, 1);
    cycle(11'h000, 1, 0);
    chk("t4_cleared_valid", out_valid, 0);
    chk("t4_cleared_count", hit_count, 0);
    repeat (4) cycle(11'h000, 1, 0);
    chk("t4_no_104", out_valid, 0);
    cycle(11'h010, 1, 0);
    cycle(11'h000, 1, 0);
    cycle(11'h000, 1, 0);
    chk("t4_later_104", out_index, 104);

    // asynchronous reset mid-drain
    cycle(11'h000, 1, 1);
    cycle(11'h0F0, 0, 0);
    cycle(11'h000, 0, 0);
    cycle(11'h000, 0, 0);
    chk("t5_pre_index", out_index, 104);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_index", out_index, 0);
    chk("t5_async_count", hit_count, 0);
    chk("t5_async_all", all_covered, 0);
    valid = '0;
    out_ready = 1'b1;
    clear = 1'b0;
    mreset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (6) cycle(11'h000, 1, 0);
    chk("t5_no_stale", out_valid, 0);

    // randomized traffic with rare clears
    cycle(11'h000, 1, 1);
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] v;
      v = N'($urandom & $urandom & $urandom);
      cycle(v, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    repeat (20) cycle(11'h000, 1, 0);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
